// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM stage controller: FSM state
// encoding, data/register widths, pipeline-register structs and helpers.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RN_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
        logic [RN_W-1:0]   rn;
        logic              wreg;
        logic              m2reg;
        logic              wmem;
    } exmem_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic              m2reg;
        logic [RN_W-1:0]   rn;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
        logic              exc;
    } memwb_t;

    function automatic logic is_mem_op(input logic m2reg, input logic wmem);
        return m2reg | wmem;
    endfunction

    function automatic logic misaligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pipemem_ctrl_if.sv
// Data-memory request/response bus between the MEM stage and memory.
interface pipemem_ctrl_if;
    import pipe_pkg::*;

    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ready
    );

endinterface

// File: rtl/pipemem_ctrl_mwreg.sv
// MEM/WB pipeline register. Updates every edge: a retiring instruction is
// loaded, otherwise a bubble (valid/wreg/exc cleared, the rest held).
// Load data is only refreshed on a load retire so WB sees a stable value.
module pipemwreg
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              retire,
    input  logic              ld,
    input  logic              exc,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic [RN_W-1:0]   rn,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] rdata,
    output logic              mvalid,
    output logic              mwreg,
    output logic              mm2reg,
    output logic [RN_W-1:0]   mrn,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mmo,
    output logic              mexc
);

    memwb_t wb_q, wb_d;

    // next MEM/WB contents: retire or bubble
    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = retire;
        wb_d.wreg  = retire & wreg;
        wb_d.exc   = retire & exc;
        if (retire) begin
            wb_d.m2reg = m2reg;
            wb_d.rn    = rn;
            wb_d.alu   = alu;
        end
        if (ld) begin
            wb_d.mo = rdata;
        end
    end

    // MEM/WB register, cleared asynchronously
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) wb_q <= '0;
        else         wb_q <= wb_d;
    end

    assign mvalid = wb_q.valid;
    assign mwreg  = wb_q.wreg;
    assign mm2reg = wb_q.m2reg;
    assign mrn    = wb_q.rn;
    assign malu   = wb_q.alu;
    assign mmo    = wb_q.mo;
    assign mexc   = wb_q.exc;

endmodule

// File: rtl/pipemem_ctrl.sv
// MEM stage controller: EX/MEM register, IDLE/WAIT access FSM driving the
// data-memory bus, stall generation and the MEM/WB register.
// Build option MEM_MISALIGN_CHECK_EN: misaligned loads/stores skip the bus
// and retire with mexc=1; without it the bus address is word-aligned and
// mexc is tied low.
module pipemem_ctrl
    import pipe_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  evalid,
    input  logic [DATA_W-1:0]     ealu,
    input  logic [DATA_W-1:0]     eb,
    input  logic [RN_W-1:0]       ern,
    input  logic                  ewreg,
    input  logic                  em2reg,
    input  logic                  ewmem,
    output logic                  mem_stall,
    pipemem_ctrl_if.master        dm,
    output logic                  mvalid,
    output logic                  mwreg,
    output logic                  mm2reg,
    output logic [RN_W-1:0]       mrn,
    output logic [DATA_W-1:0]     malu,
    output logic [DATA_W-1:0]     mmo,
    output logic                  mexc
);

    exmem_t     em_q, em_d;
    mem_state_e state_q, state_d;

    logic              e_mis;     // incoming op is a misaligned memory access
    logic              m_mis;     // held op is a misaligned memory access
    logic              retire;
    logic              ld_retire;
    logic              req_v, we_v;
    logic [DATA_W-1:0] addr_v, wdata_v;

`ifdef MEM_MISALIGN_CHECK_EN
    assign e_mis = misaligned(ealu);
    assign m_mis = em_q.valid && is_mem_op(em_q.m2reg, em_q.wmem) && misaligned(em_q.alu);
`else
    assign e_mis = 1'b0;
    assign m_mis = 1'b0;
`endif

    // Only an outstanding access that memory has not yet completed freezes
    // upstream; completion and capture of the next op share the same edge.
    assign mem_stall = (state_q == WAIT) && !dm.dm_ready;

    // EX/MEM capture when not stalled, hold otherwise
    always_comb begin
        em_d = em_q;
        if (!mem_stall) begin
            em_d.valid = evalid;
            em_d.alu   = ealu;
            em_d.b     = eb;
            em_d.rn    = ern;
            em_d.wreg  = ewreg;
            em_d.m2reg = em2reg;
            em_d.wmem  = ewmem;
        end
    end

    // FSM next state: follows whatever is being captured; WAIT holds on stall
    always_comb begin
        state_d = state_q;
        if (!mem_stall) begin
            state_d = IDLE;
            if (evalid && is_mem_op(em2reg, ewmem) && !e_mis) state_d = WAIT;
        end
    end

    // EX/MEM register and FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            em_q    <= '0;
            state_q <= IDLE;
        end else begin
            em_q    <= em_d;
            state_q <= state_d;
        end
    end

    // data-memory bus: driven from held op while WAIT, all-zero in IDLE
    always_comb begin
        req_v   = 1'b0;
        we_v    = 1'b0;
        addr_v  = '0;
        wdata_v = '0;
        if (state_q == WAIT) begin
            req_v   = 1'b1;
            we_v    = em_q.wmem;
            addr_v  = em_q.alu;
            wdata_v = em_q.b;
`ifndef MEM_MISALIGN_CHECK_EN
            addr_v[1:0] = 2'b00;
`endif
        end
    end

    assign dm.dm_req   = req_v;
    assign dm.dm_we    = we_v;
    assign dm.dm_addr  = addr_v;
    assign dm.dm_wdata = wdata_v;

    // In IDLE a valid held op is non-memory (or misaligned) and retires at
    // once; in WAIT it retires on completion. dm_ready is ignored in IDLE.
    assign retire    = em_q.valid && ((state_q == IDLE) || dm.dm_ready);
    assign ld_retire = retire && em_q.m2reg && !m_mis;

    pipemwreg u_mwreg (
        .clock  (clock),
        .resetn (resetn),
        .retire (retire),
        .ld     (ld_retire),
        .exc    (m_mis),
        .wreg   (em_q.wreg && !em_q.wmem && !m_mis),
        .m2reg  (em_q.m2reg),
        .rn     (em_q.rn),
        .alu    (em_q.alu),
        .rdata  (dm.dm_rdata),
        .mvalid (mvalid),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .mrn    (mrn),
        .malu   (malu),
        .mmo    (mmo),
        .mexc   (mexc)
    );

endmodule

// File: tb/tb_pipemem_ctrl.sv
// Scoreboard bench for pipemem_ctrl: directed scenarios then random ops.
// Expected retires and bus requests are queued at capture time from a
// transaction-level model; monitors pop and compare on the falling edge.
module tb_pipemem_ctrl;
    import pipe_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic        evalid, ewreg, em2reg, ewmem;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        mem_stall, mvalid, mwreg, mm2reg, mexc;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;

    pipemem_ctrl_if dm_if();

    pipemem_ctrl dut (
        .clock(clock), .resetn(resetn), .evalid(evalid), .ealu(ealu), .eb(eb),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .mem_stall(mem_stall), .dm(dm_if), .mvalid(mvalid), .mwreg(mwreg),
        .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo), .mexc(mexc)
    );

    always #5 clock = ~clock;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic wreg; logic m2reg; logic [4:0] rn; logic [31:0] alu; logic [31:0] mo; logic exc;
    } ret_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

    ret_t        ret_q[$];
    req_t        req_q[$];
    logic [31:0] phys[int];   // memory as seen by the bus responder
    logic [31:0] model[int];  // memory in program order
    logic [31:0] last_mo = '0;
    int          n_cmp = 0, n_bad = 0;
    int          force_wait = -1;
    bit          idle_rdy = 1'b0;
    bit          pending = 1'b0;
    int          wcnt = 0;

    function automatic logic [31:0] dflt(input int idx);
        logic [31:0] i;
        i = idx;
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] phys_rd(input int idx);
        return phys.exists(idx) ? phys[idx] : dflt(idx);
    endfunction

    function automatic logic [31:0] model_rd(input int idx);
        return model.exists(idx) ? model[idx] : dflt(idx);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // retire monitor
    always @(negedge clock) begin
        if (resetn) begin
            chk("stall_rule", 32'(mem_stall), 32'(dm_if.dm_req & ~dm_if.dm_ready));
            if (mvalid) begin
                if (ret_q.size() == 0) fail_now("unexpected_retire");
                else begin
                    ret_t r;
                    r = ret_q.pop_front();
                    chk("ret_wreg",  32'(mwreg),  32'(r.wreg));
                    chk("ret_m2reg", 32'(mm2reg), 32'(r.m2reg));
                    chk("ret_rn",    32'(mrn),    32'(r.rn));
                    chk("ret_alu",   malu,        r.alu);
                    chk("ret_mo",    mmo,         r.mo);
                    chk("ret_exc",   32'(mexc),   32'(r.exc));
                end
            end else begin
                chk("bubble_mwreg", 32'(mwreg), 32'd0);
            end
        end
    end

    // bus monitor: checks completed requests, commits stores
    always @(negedge clock) begin
        if (resetn) begin
            if (dm_if.dm_req && dm_if.dm_ready) begin
                if (req_q.size() == 0) fail_now("unexpected_request");
                else begin
                    req_t q;
                    q = req_q.pop_front();
                    chk("req_addr",  dm_if.dm_addr,      q.addr);
                    chk("req_we",    32'(dm_if.dm_we),   32'(q.we));
                    chk("req_wdata", dm_if.dm_wdata,     q.wdata);
                    if (q.we) phys[int'(q.addr >> 2)] = q.wdata;
                end
                pending = 1'b0;
            end else if (!dm_if.dm_req) begin
                chk("idle_bus", 32'(dm_if.dm_we) | dm_if.dm_addr | dm_if.dm_wdata, 32'd0);
            end
        end
    end

    // memory responder: random or forced wait states, noise on dm_ready in idle
    always @(posedge clock) begin
        #1;
        if (!resetn) begin
            pending        = 1'b0;
            dm_if.dm_ready = 1'b0;
        end else if (dm_if.dm_req) begin
            if (!pending) begin
                pending = 1'b1;
                wcnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            end
            if (wcnt == 0) begin
                dm_if.dm_ready = 1'b1;
                dm_if.dm_rdata = phys_rd(int'(dm_if.dm_addr >> 2));
            end else begin
                dm_if.dm_ready = 1'b0;
                dm_if.dm_rdata = $urandom;
                wcnt--;
            end
        end else begin
            dm_if.dm_ready = idle_rdy | 1'($urandom_range(0, 1));
            dm_if.dm_rdata = $urandom;
        end
    end

    // present an op (from posedge+1), hold it until captured, queue expectations
    task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rn, input logic wr);
        int   g;
        bit   mis;
        ret_t r;
        req_t q;
        evalid = 1'b1; ealu = a; eb = b; ern = rn; ewreg = wr;
        em2reg = (kind == 1); ewmem = (kind == 2);
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (mem_stall && g < 64);
        if (mem_stall) begin
            fail_now("issue_timeout");
        end else begin
            mis = MIS_EN && (kind != 0) && (a[1:0] != 2'b00);
            if (kind == 1 && !mis) last_mo = model_rd(int'(a >> 2));
            if (kind == 2 && !mis) model[int'(a >> 2)] = b;
            r.wreg = wr && (kind != 2) && !mis;
            r.m2reg = (kind == 1);
            r.rn = rn; r.alu = a; r.mo = last_mo; r.exc = mis;
            ret_q.push_back(r);
            if (kind != 0 && !mis) begin
                q.we = (kind == 2); q.addr = a & 32'hFFFF_FFFC; q.wdata = b;
                req_q.push_back(q);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        evalid = 1'b0; ealu = $urandom; eb = $urandom;
        em2reg = 1'($urandom); ewmem = 1'($urandom); ewreg = 1'($urandom);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic preset(input int idx, input logic [31:0] v);
        phys[idx] = v;
        model[idx] = v;
    endtask

    initial begin
        int          g;
        logic [31:0] a;
        resetn = 1'b0;
        evalid = 1'b0; ealu = '0; eb = '0; ern = '0; ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
        dm_if.dm_ready = 1'b0; dm_if.dm_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ctrl", 32'({mvalid, mwreg, mm2reg, mexc, dm_if.dm_req, dm_if.dm_we, mem_stall, mrn}), 32'd0);
        chk("rst_malu", malu, 32'd0);
        chk("rst_mmo",  mmo,  32'd0);
        chk("rst_bus",  dm_if.dm_addr | dm_if.dm_wdata, 32'd0);
        resetn = 1'b1;

        // ALU op: retires two edges after presentation, no stall
        issue(0, 32'h1234, 32'h0, 5'd7, 1'b1);
        evalid = 1'b0;
        @(negedge clock);
        chk("alu_lat1_mvalid", 32'(mvalid), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("alu_lat2_mvalid", 32'(mvalid), 32'd1);
        chk("alu_malu", malu, 32'h1234);
        @(posedge clock); #1;

        // zero-wait load
        preset(32'h40, 32'hDEAD_BEEF);
        force_wait = 0;
        issue(1, 32'h100, 32'h0, 5'd3, 1'b1);
        evalid = 1'b0;
        @(negedge clock);
        chk("ld_req", 32'(dm_if.dm_req), 32'd1);
        chk("ld_addr", dm_if.dm_addr, 32'h100);
        @(posedge clock); #1;
        @(negedge clock);
        chk("ld_mvalid", 32'(mvalid), 32'd1);
        chk("ld_mmo", mmo, 32'hDEAD_BEEF);
        chk("ld_req_drop", 32'(dm_if.dm_req), 32'd0);
        @(posedge clock); #1;

        // store with three wait states
        force_wait = 3;
        issue(2, 32'h200, 32'h55, 5'd2, 1'b1);
        evalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("st_wait_stall", 32'(mem_stall), 32'd1);
            chk("st_wait_we", 32'(dm_if.dm_we), 32'd1);
            chk("st_wait_mvalid", 32'(mvalid), 32'd0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("st_done_stall", 32'(mem_stall), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("st_mvalid", 32'(mvalid), 32'd1);
        chk("st_mwreg", 32'(mwreg), 32'd0);
        @(posedge clock); #1;

        // back-to-back zero-wait loads
        force_wait = 0;
        issue(1, 32'h10, 32'h0, 5'd4, 1'b1);
        issue(1, 32'h20, 32'h0, 5'd5, 1'b1);
        evalid = 1'b0;
        @(negedge clock);
        chk("b2b_req", 32'(dm_if.dm_req), 32'd1);
        chk("b2b_addr_b", dm_if.dm_addr, 32'h20);
        chk("b2b_first_retire", 32'(mvalid), 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("b2b_second_retire", 32'(mvalid), 32'd1);
        @(posedge clock); #1;

        // reset in the second WAIT cycle of a load
        force_wait = 5;
        issue(1, 32'h300, 32'h0, 5'd6, 1'b1);
        evalid = 1'b0;
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        chk("rst_wait_req", 32'(dm_if.dm_req), 32'd0);
        chk("rst_wait_ctrl", 32'({mvalid, mwreg, mm2reg, mexc, dm_if.dm_we, mem_stall, mrn}), 32'd0);
        chk("rst_wait_bus", dm_if.dm_addr | malu | mmo, 32'd0);
        ret_q.delete();
        req_q.delete();
        last_mo = '0;
        idle_rdy = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("late_ready_no_retire", 32'(mvalid), 32'd0);
            @(posedge clock); #1;
        end
        idle_rdy = 1'b0;

        // misaligned load
        force_wait = 0;
        issue(1, 32'h102, 32'h0, 5'd9, 1'b1);
        evalid = 1'b0;
        @(negedge clock);
        if (MIS_EN) chk("mis_no_req", 32'(dm_if.dm_req), 32'd0);
        else        chk("mis_addr_aligned", dm_if.dm_addr, 32'h100);
        @(posedge clock); #1;
        @(negedge clock);
        chk("mis_mvalid", 32'(mvalid), 32'd1);
        chk("mis_mexc", 32'(mexc), 32'(MIS_EN));
        @(posedge clock); #1;

        // random traffic
        force_wait = -1;
        repeat (300) begin
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(int'($urandom_range(0, 2)), a, $urandom, 5'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        // drain
        idle(0);
        g = 0;
        while ((ret_q.size() != 0 || req_q.size() != 0) && g < 100) begin
            @(posedge clock); #1;
            g++;
        end
        chk("drain_retires", 32'(ret_q.size()), 32'd0);
        chk("drain_requests", 32'(req_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
